// File: rtl/uart_tx_serializer.sv
// Byte-wide 8N1 UART transmitter fed by a small FIFO from a CPU MMIO write strobe.
// Frames are sent back-to-back with no idle gap while the FIFO holds data.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [8:0]                    uart_in,
  output logic                          tx,
  output logic                          busy,
  output logic                          fifo_full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [1:0]    state_reg;
  logic [BW-1:0] baud_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic          overflow_reg;

  logic baud_end;
  logic fifo_empty;
  logic fifo_full_int;
  logic strobe;
  logic pop;
  logic push;
  logic drop;

  assign baud_end      = (baud_cnt_reg == BAUD_LAST);
  assign fifo_empty    = (level_reg == '0);
  assign fifo_full_int = (level_reg == LVL_FULL);
  assign strobe        = uart_in[8];

  // A pop happens when idle, or at the last edge of a stop bit, so a full FIFO can still accept.
  assign pop  = !fifo_empty && ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && baud_end));
  assign push = strobe && (!fifo_full_int || pop);
  assign drop = strobe && fifo_full_int && !pop;

  always_ff @(posedge clock) begin
    if (reset_n && push) begin
      fifo_mem[wr_ptr_reg] <= uart_in[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      if (push && !pop) begin
        level_reg <= level_reg + LVL_ONE;
      end else if (pop && !push) begin
        level_reg <= level_reg - LVL_ONE;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          tx_reg <= 1'b1;
          if (pop) begin
            shift_reg    <= fifo_mem[rd_ptr_reg];
            state_reg    <= ST_START;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            tx_reg       <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            state_reg    <= ST_DATA;
            tx_reg       <= shift_reg[0];
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_ONE;
          end
        end
        ST_DATA: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= ST_STOP;
              tx_reg    <= 1'b1;
            end else begin
              // Shift and present the next bit on the same edge so tx stays registered.
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              shift_reg   <= {1'b0, shift_reg[7:1]};
              tx_reg      <= shift_reg[1];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_ONE;
          end
        end
        ST_STOP: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            if (pop) begin
              shift_reg <= fifo_mem[rd_ptr_reg];
              state_reg <= ST_START;
              tx_reg    <= 1'b0;
            end else begin
              state_reg <= ST_IDLE;
              tx_reg    <= 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + BAUD_ONE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign tx        = tx_reg;
  assign busy      = (state_reg != ST_IDLE) || !fifo_empty;
  assign fifo_full = fifo_full_int;
  assign overflow  = overflow_reg;
  assign level     = level_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized scoreboard bench: a timing model predicts accepted bytes and frame start edges,
// a line monitor decodes every frame and checks it cycle by cycle against the queue head.
module tb_uart_tx_serializer;

  localparam int C = 4;
  localparam int D = 4;
  localparam int FRAME = 10 * C;

  typedef struct {
    logic [7:0] b;
    int         start;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [8:0] uart_in = '0;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic       overflow;
  logic [2:0] level;

  uart_tx_serializer #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .uart_in   (uart_in),
    .tx        (tx),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow),
    .level     (level)
  );

  initial forever #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: each accepted byte owns a frame starting at max(accept+1, end of previous frame).
  int   pend_q[$];
  exp_t sb_q[$];
  int   line_free  = 0;
  int   last_start = -1000;
  bit   m_ovf      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_level();
    int n = 0;
    foreach (pend_q[i]) if (pend_q[i] > cyc) n++;
    return n;
  endfunction

  function automatic bit exp_busy();
    return (exp_level() > 0) || (cyc >= last_start && cyc < last_start + FRAME);
  endfunction

  task automatic prune(input int upto);
    while (pend_q.size() > 0 && pend_q[0] < upto) void'(pend_q.pop_front());
  endtask

  // Called at a falling edge; inputs apply to the next rising edge, returns at the following falling edge.
  task automatic drive(input bit v, input logic [7:0] b);
    int e;
    int s;
    bit pop_now;
    e = cyc + 1;
    uart_in = {v, b};
    prune(e);
    pop_now = (pend_q.size() > 0) && (pend_q[0] == e);
    if (v) begin
      if (pend_q.size() < D || pop_now) begin
        s = (e + 1 > line_free) ? e + 1 : line_free;
        line_free  = s + FRAME;
        last_start = s;
        pend_q.push_back(s);
        sb_q.push_back('{b: b, start: s});
        $display("strobe %02h at edge %0d accepted, frame expected at edge %0d", b, e, s);
      end else begin
        m_ovf = 1'b1;
        $display("strobe %02h at edge %0d dropped (fifo full)", b, e);
      end
    end
    @(negedge clock);
    uart_in = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  task automatic do_reset(input int n_edges, input logic [7:0] b);
    reset_n = 1'b0;
    uart_in = {1'b1, b};
    pend_q.delete();
    sb_q.delete();
    line_free  = 0;
    last_start = -1000;
    m_ovf      = 1'b0;
    repeat (n_edges) @(negedge clock);
    reset_n = 1'b1;
    uart_in = '0;
    $display("reset applied for %0d edges, ending at edge %0d", n_edges, cyc);
  endtask

  task automatic status(input string tag);
    int lv;
    lv = exp_level();
    check({tag, "_level"}, 32'(level), 32'(lv));
    check({tag, "_fifo_full"}, 32'(fifo_full), 32'(lv == D));
    check({tag, "_busy"}, 32'(busy), 32'(exp_busy()));
    check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while ((sb_q.size() > 0 || mon_active || exp_busy()) && g < 3000) begin
      idle(1);
      g++;
    end
    check({tag, "_drain_in_time"}, 32'(g < 3000), 32'd1);
  endtask

  // Line monitor: on each start bit, pop the expected frame and compare every cycle of it.
  bit         mon_active = 1'b0;
  int         mon_t0     = 0;
  int         mon_bad    = 0;
  exp_t       mon_exp;
  logic [7:0] mon_obs;

  initial begin
    int   o;
    int   idx;
    logic expb;
    forever begin
      @(posedge clock);
      #1;
      if (!reset_n) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active && tx === 1'b0) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_frame: start bit at edge %0d, expected none", cyc);
            mon_exp = '{b: 8'h00, start: cyc};
          end else begin
            mon_exp = sb_q.pop_front();
            check("frame_start_edge", 32'(cyc), 32'(mon_exp.start));
          end
          mon_active = 1'b1;
          mon_t0     = cyc;
          mon_bad    = 0;
          mon_obs    = '0;
        end
        if (mon_active) begin
          o    = cyc - mon_t0;
          idx  = o / C;
          expb = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : mon_exp.b[idx-1];
          if (tx !== expb) mon_bad++;
          if ((o % C) == C / 2 && idx >= 1 && idx <= 8) mon_obs[idx-1] = tx;
          if (o == FRAME - 1) begin
            check("frame_data", 32'(mon_obs), 32'(mon_exp.b));
            check("frame_shape_bad_cycles", 32'(mon_bad), 32'd0);
            $display("frame byte %02h from edge %0d decoded %02h, bad cycles %0d",
                     mon_exp.b, mon_t0, mon_obs, mon_bad);
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int t0;
    int s;
    int g;
    @(negedge clock);

    // Reset with a strobe present must leave everything empty.
    do_reset(3, 8'h77);
    status("reset");
    check("reset_tx", 32'(tx), 32'd1);
    idle(5);
    status("post_reset");

    // Single 0x55: busy through the stop bit, idle right after.
    drive(1'b1, 8'h55);
    status("single_after_strobe");
    idle(40);
    status("single_in_stop");
    idle(1);
    status("single_done");
    check("single_tx_idle", 32'(tx), 32'd1);

    // Two bytes back to back: adjacent frames.
    drive(1'b1, 8'h41);
    drive(1'b1, 8'h42);
    drain("pair");

    // Six strobes while idle: one in flight, four buffered, last dropped.
    for (int i = 1; i <= 6; i++) drive(1'b1, 8'(i));
    status("burst6");
    check("burst6_overflow", 32'(overflow), 32'd1);
    drain("burst6");
    status("burst6_sticky");

    // Full FIFO with a strobe landing on the stop-bit pop edge.
    do_reset(1, 8'h00);
    status("fill_reset");
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h10 + i));
    status("fill_full");
    g = 0;
    prune(cyc + 1);
    while (!(pend_q.size() > 0 && pend_q[0] == cyc + 1) && g < 200) begin
      idle(1);
      prune(cyc + 1);
      g++;
    end
    check("fill_wait_pop_edge", 32'(g < 200), 32'd1);
    drive(1'b1, 8'hAA);
    status("coincident_push_pop");
    drain("fill");

    // Reset during data bit 3 of 0xF0 with two bytes queued.
    t0 = cyc;
    drive(1'b1, 8'hF0);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    s = t0 + 2;
    idle(s + 16 - cyc);
    do_reset(1, 8'h00);
    status("abort");
    check("abort_tx", 32'(tx), 32'd1);
    idle(100);
    status("abort_quiet");

    // All-zero and all-one data bytes.
    drive(1'b1, 8'h00);
    drive(1'b1, 8'hFF);
    drain("extremes");

    // Random traffic with gaps that both starve and overrun the FIFO.
    for (int i = 0; i < 80; i++) begin
      idle($urandom_range(0, 12));
      drive(1'b1, 8'($urandom));
      if (i % 10 == 9) status("random");
    end
    drain("random");
    status("final");
    check("final_tx", 32'(tx), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, edge %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
